gp_regfile_sweep: RTL and testbench
===================================

Name: gp_regfile_sweep

Overview:
Parametrised next-generation general-purpose register bank for the Mini SRC datapath. It keeps the vectorised one-hot GRin/GRout bus interface and the BAout zero-on-R0 rule. It adds:
- configurable width and depth;
- a second binary-addressed debug read port;
- one-hot select checking;
- a multi-cycle clear sequencer that sweeps CLR_VAL into the registers one per cycle.

It sits on the internal bus between BusMuxOut and the bus multiplexer input.

Parameters:
DATA_W, 32, register and bus width in bits.
NUM_REGS, 16, number of registers (>=2). Localparam AW = $clog2(NUM_REGS).
CLR_VAL, 0 (DATA_W bits), value loaded by reset and by the clear sweep.

Ports:
clk  input  1  rising-edge clock.
reg_clear_n  input  1  asynchronous active-low reset.
clr_start  input  1  single-cycle request to start a clear sweep.
BAout  input  1  base-address read mode; R0 reads as zero.
BusMuxOut  input  DATA_W  bus write data.
GRin  input  NUM_REGS  one-hot write enables (bit i = Ri).
GRout  input  NUM_REGS  one-hot bus read selects.
dbg_addr  input  AW  binary debug read address.
BusMuxIn  output  DATA_W  bus read data.
dbg_data  output  DATA_W  debug read data.
busy  output  1  high while the sweep runs.
clr_done  output  1  one-cycle pulse when the sweep finishes.
sel_err  output  1  registered flag: illegal GRin/GRout pattern in the previous cycle.
wr_drop  output  1  registered pulse: a valid write was discarded in the previous cycle.

Behaviour:
- Reset (reg_clear_n low, asynchronous):
  - all registers = CLR_VAL;
  - FSM = IDLE, sweep index = 0;
  - busy = 0, clr_done = 0, sel_err = 0, wr_drop = 0.
  - Reset mid-sweep aborts the sweep; clr_done does not pulse.
- Write decode:
  - GRin all-zero: no write.
  - GRin exactly one bit i set: Ri <= BusMuxOut at the clock edge.
  - GRin with more than one bit set: no register is written; sel_err = 1 next cycle.
  - R0 is writable; BAout affects reads only.
- Bus read (combinational, zero latency):
  - GRout one-hot at bit i: BusMuxIn = Ri.
  - Exception: GRout[0] && BAout gives BusMuxIn = 0.
  - GRout all-zero: BusMuxIn = 0.
  - GRout with more than one bit set: BusMuxIn = 0, and sel_err = 1 next cycle.
- Debug read (combinational): dbg_data = R[dbg_addr]. dbg_addr >= NUM_REGS returns 0. BAout is ignored.
- sel_err is recomputed every cycle; it is not sticky.
- FSM:
  - IDLE -> SWEEP on clr_start; index = 0; busy = 1 from the next cycle.
  - In SWEEP, each cycle R[index] <= CLR_VAL, then index++.
  - After R[NUM_REGS-1] is written: SWEEP -> IDLE, busy = 0, clr_done = 1 for exactly that following cycle.
  - Sweep length = NUM_REGS cycles. The first cleared register is R0, in the first busy cycle.
- clr_start while busy is ignored (no restart, no error).
- Bus writes while busy:
  - a valid one-hot GRin is discarded;
  - wr_drop = 1 next cycle;
  - the sweep always wins.
- Bus reads while busy are allowed and return current contents (partially cleared).
- Write and read of the same register in the same cycle: BusMuxIn shows the old value. There is no write-through.
- Width rules:
  - all data paths are DATA_W bits;
  - index width is AW;
  - the last-index compare is against NUM_REGS-1, so non-power-of-two depths are supported.

Test Plan:
1. Reset, then GRin=16'h0008 with BusMuxOut=32'hDEADBEEF, then GRout=16'h0008 -> BusMuxIn=32'hDEADBEEF. Before the write, all reads = 0.
2. Write R0=32'h00000055. GRout=16'h0001 with BAout=0 -> 32'h00000055. With BAout=1 -> 32'h0; dbg_addr=0 still gives 32'h00000055.
3. GRin=16'h0011 with BusMuxOut=32'h12345678 -> R0 and R4 unchanged, sel_err=1 for one cycle. GRout=16'h0300 -> BusMuxIn=0, sel_err=1 next cycle.
4. Write R5=32'hA5A5A5A5, R15=32'h1 (DATA_W=32, NUM_REGS=16), pulse clr_start:
   - busy high for 16 cycles;
   - after cycle 6, dbg_addr=5 -> 0;
   - clr_done pulses once;
   - all registers = 0.
5. During a sweep, assert GRin=16'h0002 with BusMuxOut=32'h77 at busy cycle 3, and pulse clr_start again -> wr_drop=1 next cycle, R1=0 at the end, sweep length still 16.
6. Deassert reg_clear_n at busy cycle 8 -> busy=0 immediately, all registers = CLR_VAL, no clr_done. Repeat with NUM_REGS=12, DATA_W=16, CLR_VAL=16'hFFFF -> sweep lasts 12 cycles, all reads = 16'hFFFF.

Source files
------------

// File: rtl/gp_regfile_sweep.sv
// General-purpose register bank for the Mini SRC datapath: one-hot bus write/read,
// binary debug read port, select-pattern checking and a one-register-per-cycle clear sweep.
module gp_regfile_sweep #(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
  input  logic                        clk,
  input  logic                        reg_clear_n,
  input  logic                        clr_start,
  input  logic                        BAout,
  input  logic [DATA_W-1:0]           BusMuxOut,
  input  logic [NUM_REGS-1:0]         GRin,
  input  logic [NUM_REGS-1:0]         GRout,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]           BusMuxIn,
  output logic [DATA_W-1:0]           dbg_data,
  output logic                        busy,
  output logic                        clr_done,
  output logic                        sel_err,
  output logic                        wr_drop
);

  localparam int            AW       = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t             state_q;
  logic [AW-1:0]      idx_q;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic               busy_q;
  logic               clr_done_q;
  logic               sel_err_q;
  logic               wr_drop_q;

  logic               gr_in_any;
  logic               gr_in_onehot;
  logic               gr_in_multi;
  logic               gr_out_any;
  logic               gr_out_onehot;
  logic               gr_out_multi;
  logic [AW-1:0]      wr_idx;
  logic [DATA_W-1:0]  bus_rd;

  // A vector is one-hot when it is non-zero and clearing its lowest set bit leaves zero.
  always_comb begin
    gr_in_any     = |GRin;
    gr_in_onehot  = gr_in_any && ((GRin & (GRin - NUM_REGS'(1))) == '0);
    gr_in_multi   = gr_in_any && !gr_in_onehot;
    gr_out_any    = |GRout;
    gr_out_onehot = gr_out_any && ((GRout & (GRout - NUM_REGS'(1))) == '0);
    gr_out_multi  = gr_out_any && !gr_out_onehot;
  end

  always_comb begin
    wr_idx = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (GRin[i]) wr_idx = AW'(i);
    end
  end

  always_comb begin
    bus_rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (GRout[i]) bus_rd = regs_q[i];
    end
    BusMuxIn = (gr_out_onehot && !(GRout[0] && BAout)) ? bus_rd : '0;
  end

  // Addresses past the last register fall through to zero.
  always_comb begin
    dbg_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dbg_addr == AW'(i)) dbg_data = regs_q[i];
    end
  end

  // Handshake: clr_start is a one-cycle request accepted only when busy is low;
  // busy acts as not-ready and clr_done marks completion, there is no back-pressure.
  always_ff @(posedge clk or negedge reg_clear_n) begin
    if (!reg_clear_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= CLR_VAL;
      state_q    <= IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
      sel_err_q  <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      sel_err_q  <= gr_in_multi || gr_out_multi;
      wr_drop_q  <= (state_q == SWEEP) && gr_in_onehot;
      clr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gr_in_onehot) regs_q[wr_idx] <= BusMuxOut;
          if (clr_start) begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
            idx_q   <= '0;
          end
        end
        SWEEP: begin
          // The sweep owns the write port; bus writes are dropped and flagged.
          regs_q[idx_q] <= CLR_VAL;
          if (idx_q == LAST_IDX) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b1;
            idx_q      <= '0;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_done = clr_done_q;
  assign sel_err  = sel_err_q;
  assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_gp_regfile_sweep.sv
// Bench for gp_regfile_sweep: directed plan steps plus random traffic checked against
// an array model, and a second 12x16 instance with an all-ones clear value.
module tb_gp_regfile_sweep;

  localparam int W  = 32;
  localparam int N  = 16;
  localparam int AW = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reg_clear_n;
  logic          clr_start;
  logic          ba_out;
  logic [W-1:0]  bus_mux_out;
  logic [N-1:0]  gr_in;
  logic [N-1:0]  gr_out;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  bus_mux_in;
  logic [W-1:0]  dbg_data;
  logic          busy;
  logic          clr_done;
  logic          sel_err;
  logic          wr_drop;

  gp_regfile_sweep #(.DATA_W(W), .NUM_REGS(N), .CLR_VAL('0)) dut (
    .clk(clk), .reg_clear_n(reg_clear_n), .clr_start(clr_start), .BAout(ba_out),
    .BusMuxOut(bus_mux_out), .GRin(gr_in), .GRout(gr_out), .dbg_addr(dbg_addr),
    .BusMuxIn(bus_mux_in), .dbg_data(dbg_data), .busy(busy), .clr_done(clr_done),
    .sel_err(sel_err), .wr_drop(wr_drop)
  );

  logic          b_rst_n;
  logic          b_clr_start;
  logic          b_ba_out;
  logic [15:0]   b_bus_out;
  logic [11:0]   b_gr_in;
  logic [11:0]   b_gr_out;
  logic [3:0]    b_dbg_addr;
  logic [15:0]   b_bus_in;
  logic [15:0]   b_dbg_data;
  logic          b_busy;
  logic          b_done;
  logic          b_sel;
  logic          b_drop;

  gp_regfile_sweep #(.DATA_W(16), .NUM_REGS(12), .CLR_VAL(16'hFFFF)) dut_small (
    .clk(clk), .reg_clear_n(b_rst_n), .clr_start(b_clr_start), .BAout(b_ba_out),
    .BusMuxOut(b_bus_out), .GRin(b_gr_in), .GRout(b_gr_out), .dbg_addr(b_dbg_addr),
    .BusMuxIn(b_bus_in), .dbg_data(b_dbg_data), .busy(b_busy), .clr_done(b_done),
    .sel_err(b_sel), .wr_drop(b_drop)
  );

  // reference model: register contents plus what the status outputs must show
  logic [W-1:0] mem [N];
  bit           m_busy, m_done, m_sel, m_drop;
  int           m_pos;
  int           total = 0;
  int           bad   = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mem[i] = '0;
    m_busy = 0; m_done = 0; m_sel = 0; m_drop = 0; m_pos = 0;
  endtask

  function automatic logic [W-1:0] exp_bus();
    if ($countones(gr_out) != 1) return '0;
    for (int i = 0; i < N; i++)
      if (gr_out[i]) return (i == 0 && ba_out) ? '0 : mem[i];
    return '0;
  endfunction

  // apply one clock edge's worth of behaviour to the model
  task automatic model_edge();
    int n_in;
    n_in   = $countones(gr_in);
    m_sel  = (n_in > 1) || ($countones(gr_out) > 1);
    m_drop = m_busy && (n_in == 1);
    m_done = 0;
    if (m_busy) begin
      mem[m_pos] = '0;
      m_pos++;
      if (m_pos == N) begin m_busy = 0; m_done = 1; end
    end else begin
      if (n_in == 1)
        for (int i = 0; i < N; i++) if (gr_in[i]) mem[i] = bus_mux_out;
      if (clr_start) begin m_busy = 1; m_pos = 0; end
    end
  endtask

  // driver tasks
  task automatic drive(input logic [N-1:0] gi, input logic [N-1:0] go, input logic [W-1:0] bo,
                       input logic ba, input logic cs, input logic [AW-1:0] da);
    gr_in = gi; gr_out = go; bus_mux_out = bo; ba_out = ba; clr_start = cs; dbg_addr = da;
  endtask

  task automatic step();
    #1;
    chk("bus_in", bus_mux_in, exp_bus());
    chk("dbg", dbg_data, mem[dbg_addr]);
    @(posedge clk);
    #1;
    model_edge();
    chk("sel_err", W'(sel_err), W'(m_sel));
    chk("wr_drop", W'(wr_drop), W'(m_drop));
    chk("busy", W'(busy), W'(m_busy));
    chk("clr_done", W'(clr_done), W'(m_done));
  endtask

  function automatic logic [N-1:0] rand_sel(input int kind);
    int a, b;
    a = $urandom_range(0, N - 1);
    b = (a + $urandom_range(1, N - 1)) % N;
    if (kind <= 3) return '0;
    if (kind <= 8) return N'(1) << a;
    return (N'(1) << a) | (N'(1) << b);
  endfunction

  int cnt, dcnt;

  initial begin
    reg_clear_n = 1'b0;
    drive('0, '0, '0, 1'b0, 1'b0, '0);
    b_rst_n = 1'b0; b_clr_start = 1'b0; b_ba_out = 1'b0; b_bus_out = '0;
    b_gr_in = '0; b_gr_out = '0; b_dbg_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(clr_done), '0);
    chk("rst_sel", W'(sel_err), '0);
    chk("rst_drop", W'(wr_drop), '0);
    @(negedge clk);
    reg_clear_n = 1'b1;
    b_rst_n = 1'b1;
    @(posedge clk); #1;

    // plan 1: everything reads zero, then R3 write/read
    for (int i = 0; i < N; i++) begin
      drive('0, N'(1) << i, '0, 1'b0, 1'b0, AW'(i));
      step();
    end
    drive(16'h0008, '0, 32'hDEADBEEF, 1'b0, 1'b0, '0); step();
    drive('0, 16'h0008, '0, 1'b0, 1'b0, 4'd3); #1;
    chk("p1_r3", bus_mux_in, 32'hDEADBEEF);
    step();

    // plan 2: R0 with and without BAout
    drive(16'h0001, '0, 32'h55, 1'b0, 1'b0, '0); step();
    drive('0, 16'h0001, '0, 1'b0, 1'b0, 4'd0); #1;
    chk("p2_r0", bus_mux_in, 32'h55);
    step();
    drive('0, 16'h0001, '0, 1'b1, 1'b0, 4'd0); #1;
    chk("p2_baout", bus_mux_in, 32'h0);
    chk("p2_dbg_r0", dbg_data, 32'h55);
    step();

    // plan 3: illegal select patterns
    drive(16'h0011, '0, 32'h12345678, 1'b0, 1'b0, '0); step();
    chk("p3_sel_wr", W'(sel_err), 32'h1);
    drive('0, '0, '0, 1'b0, 1'b0, 4'd4); step();
    chk("p3_sel_clr", W'(sel_err), 32'h0);
    drive('0, 16'h0300, '0, 1'b0, 1'b0, 4'd0); #1;
    chk("p3_multi_rd", bus_mux_in, 32'h0);
    step();
    chk("p3_sel_rd", W'(sel_err), 32'h1);

    // plan 4: full sweep timing
    drive(16'h0020, '0, 32'hA5A5A5A5, 1'b0, 1'b0, '0); step();
    drive(16'h8000, '0, 32'h1, 1'b0, 1'b0, '0); step();
    drive('0, '0, '0, 1'b0, 1'b1, 4'd5); step();
    cnt = busy; dcnt = 0;
    drive('0, '0, '0, 1'b0, 1'b0, 4'd5);
    for (int i = 0; i < 20; i++) begin
      step();
      cnt += busy; dcnt += clr_done;
    end
    chk("p4_busy_len", W'(cnt), 32'd16);
    chk("p4_done_cnt", W'(dcnt), 32'd1);
    for (int i = 0; i < N; i++) begin
      dbg_addr = AW'(i); #1;
      chk("p4_cleared", dbg_data, 32'h0);
    end

    // plan 5: write and restart attempts during a sweep
    drive(16'h0002, '0, 32'h99, 1'b0, 1'b0, '0); step();
    drive('0, '0, '0, 1'b0, 1'b1, 4'd1); step();
    cnt = busy; dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) drive(16'h0002, '0, 32'h77, 1'b0, 1'b1, 4'd1);
      else        drive('0, '0, '0, 1'b0, 1'b0, 4'd1);
      step();
      if (i == 1) chk("p5_wr_drop", W'(wr_drop), 32'h1);
      cnt += busy; dcnt += clr_done;
    end
    chk("p5_busy_len", W'(cnt), 32'd16);
    chk("p5_done_cnt", W'(dcnt), 32'd1);
    chk("p5_r1", dbg_data, 32'h0);

    // plan 6: reset in the middle of a sweep
    for (int i = 0; i < N; i++) begin
      drive(N'(1) << i, '0, $urandom, 1'b0, 1'b0, '0); step();
    end
    drive('0, '0, '0, 1'b0, 1'b1, '0); step();
    drive('0, '0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) step();
    chk("p6_busy_pre", W'(busy), 32'h1);
    reg_clear_n = 1'b0; #1;
    model_reset();
    chk("p6_busy_rst", W'(busy), 32'h0);
    chk("p6_done_rst", W'(clr_done), 32'h0);
    for (int i = 0; i < N; i++) begin
      dbg_addr = AW'(i); #1;
      chk("p6_reg_rst", dbg_data, 32'h0);
    end
    @(negedge clk);
    reg_clear_n = 1'b1;
    @(posedge clk); #1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive('0, '0, '0, 1'b0, 1'b0, AW'(i)); step();
      dcnt += clr_done;
    end
    chk("p6_no_done", W'(dcnt), 32'd0);

    // 12 x 16 instance with CLR_VAL = FFFF
    for (int a = 0; a < 16; a++) begin
      b_dbg_addr = 4'(a); #1;
      chk("s_rst_rd", W'(b_dbg_data), (a < 12) ? 32'hFFFF : 32'h0);
    end
    b_gr_in = 12'h008; b_bus_out = 16'h1234;
    @(posedge clk); #1;
    b_gr_in = 12'h003; b_bus_out = 16'h0BAD; b_gr_out = 12'h008; #1;
    chk("s_r3", W'(b_bus_in), 32'h1234);
    @(posedge clk); #1;
    b_gr_in = '0;
    chk("s_sel", W'(b_sel), 32'h1);
    b_dbg_addr = 4'd1; #1;
    chk("s_r1_kept", W'(b_dbg_data), 32'hFFFF);
    b_clr_start = 1'b1;
    @(posedge clk); #1;
    b_clr_start = 1'b0;
    cnt = b_busy; dcnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      cnt += b_busy; dcnt += b_done;
    end
    chk("s_busy_len", W'(cnt), 32'd12);
    chk("s_done_cnt", W'(dcnt), 32'd1);
    for (int i = 0; i < 12; i++) begin
      b_gr_out = 12'(1) << i; #1;
      chk("s_swept", W'(b_bus_in), 32'hFFFF);
    end
    b_gr_out = 12'h001; b_ba_out = 1'b1; #1;
    chk("s_baout", W'(b_bus_in), 32'h0);
    b_gr_out = '0; b_ba_out = 1'b0;

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(rand_sel($urandom_range(0, 9)), rand_sel($urandom_range(0, 9)), $urandom,
            1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0), AW'($urandom_range(0, N - 1)));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
